// File: rtl/button_events_pkg.sv
// Shared types and 12 MHz timing defaults for the button_events input conditioning block.
package button_events_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  localparam int DEBOUNCE_12M = 240000;
  localparam int LONG_12M     = 12000000;
  localparam int REPEAT_12M   = 2400000;

endpackage

// File: rtl/button_events_channel.sv
// One button channel: 2-flop synchroniser, debounce FSM, hold timer and registered event pulses.
// Auto-repeat of press_pulse after a long press is built only when BUTTON_EVENTS_REPEAT_EN is defined.
module button_channel
  import button_events_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_12M,
  parameter int LONG_CYCLES     = LONG_12M
`ifdef BUTTON_EVENTS_REPEAT_EN
  , parameter int REPEAT_CYCLES = REPEAT_12M
`endif
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_pressed,
  output logic o_press_pulse,
  output logic o_release_pulse,
  output logic o_long_pulse
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_FULL = HOLD_W'(LONG_CYCLES);

  logic [1:0]        r_sync;
  btn_state_t        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [HOLD_W-1:0] r_hold;
  logic              r_pressed;
  logic              r_press_pulse;
  logic              r_release_pulse;
  logic              r_long_pulse;
  logic              w_s;
  logic              w_long_hit;
  logic [HOLD_W-1:0] w_hold_next;

`ifdef BUTTON_EVENTS_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RPT_W-1:0] RPT_ONE  = RPT_W'(1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
  logic [RPT_W-1:0] r_rpt;
`endif

  assign w_s         = r_sync[1];
  assign w_long_hit  = (r_hold == HOLD_PRE);
  // hold timer saturates so long_pulse can only ever match once per press
  assign w_hold_next = (r_hold == HOLD_FULL) ? r_hold : r_hold + HOLD_ONE;

  // synchroniser, debounce FSM, hold timer and event pulses
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync          <= 2'b00;
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_hold          <= '0;
      r_pressed       <= 1'b0;
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
      r_long_pulse    <= 1'b0;
`ifdef BUTTON_EVENTS_REPEAT_EN
      r_rpt           <= '0;
`endif
    end else begin
      r_sync          <= {r_sync[0], i_btn};
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
      r_long_pulse    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_s) begin
            r_state <= PRESS_WAIT;
            r_cnt   <= CNT_ONE;
          end else begin
            r_cnt <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!w_s) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state       <= HELD;
            r_cnt         <= '0;
            r_hold        <= '0;
            r_pressed     <= 1'b1;
            r_press_pulse <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        HELD: begin
          r_hold       <= w_hold_next;
          r_long_pulse <= w_long_hit;
`ifdef BUTTON_EVENTS_REPEAT_EN
          if (w_long_hit) begin
            r_rpt <= '0;
          end else if (r_hold == HOLD_FULL) begin
            if (r_rpt == RPT_LAST) begin
              r_rpt         <= '0;
              r_press_pulse <= 1'b1;
            end else begin
              r_rpt <= r_rpt + RPT_ONE;
            end
          end
`endif
          if (!w_s) begin
            r_state <= RELEASE_WAIT;
            r_cnt   <= CNT_ONE;
          end else begin
            r_cnt <= '0;
          end
        end
        RELEASE_WAIT: begin
          // the button is still logically held, so the hold timer keeps running
          r_hold       <= w_hold_next;
          r_long_pulse <= w_long_hit;
`ifdef BUTTON_EVENTS_REPEAT_EN
          if (w_long_hit) begin
            r_rpt <= '0;
          end
`endif
          if (w_s) begin
            r_state <= HELD;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            r_pressed       <= 1'b0;
            r_release_pulse <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_pressed       = r_pressed;
  assign o_press_pulse   = r_press_pulse;
  assign o_release_pulse = r_release_pulse;
  assign o_long_pulse    = r_long_pulse;

endmodule

// File: rtl/button_events.sv
// Top level: optional pin inversion followed by N_BUTTONS independent debounce channels.
// Optional auto-repeat (REPEAT_CYCLES parameter) is enabled by defining BUTTON_EVENTS_REPEAT_EN.
module button_events
  import button_events_pkg::*;
#(
  parameter int N_BUTTONS       = 3,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_12M,
  parameter int LONG_CYCLES     = LONG_12M,
  parameter int ACTIVE_LOW      = 0
`ifdef BUTTON_EVENTS_REPEAT_EN
  , parameter int REPEAT_CYCLES = REPEAT_12M
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_BUTTONS-1:0] btn_raw,
  output logic [N_BUTTONS-1:0] pressed,
  output logic [N_BUTTONS-1:0] press_pulse,
  output logic [N_BUTTONS-1:0] release_pulse,
  output logic [N_BUTTONS-1:0] long_pulse
);

  logic [N_BUTTONS-1:0] w_btn;

  assign w_btn = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

  for (genvar g = 0; g < N_BUTTONS; g++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES)
`ifdef BUTTON_EVENTS_REPEAT_EN
      , .REPEAT_CYCLES (REPEAT_CYCLES)
`endif
    ) u_channel (
      .i_clk           (clk),
      .i_rst           (reset),
      .i_btn           (w_btn[g]),
      .o_pressed       (pressed[g]),
      .o_press_pulse   (press_pulse[g]),
      .o_release_pulse (release_pulse[g]),
      .o_long_pulse    (long_pulse[g])
    );
  end

endmodule

// File: tb/tb_button_events.sv
// Self-checking bench: an active-high and an active-low instance see the same logical stimulus
// and are compared every cycle against a run-length reference model plus directed timing checks.
module tb_button_events;

  localparam int DC = 4;
  localparam int LC = 20;
  localparam int RC = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] btn_raw = 3'b000;
  logic [2:0] btn_raw_n;
  logic [2:0] pressed, press_pulse, release_pulse, long_pulse;
  logic [2:0] al_pressed, al_press_pulse, al_release_pulse, al_long_pulse;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit [2:0] m_d1 = '0, m_d2 = '0, m_prev_s = '0;
  bit [2:0] m_lvl = '0, m_pp = '0, m_rp = '0, m_lp = '0;
  int       m_run[3];
  int       m_age[3];
  int       m_rep[3];

  logic [11:0] dut_vec, al_vec, exp_vec;
  assign dut_vec   = {pressed, press_pulse, release_pulse, long_pulse};
  assign al_vec    = {al_pressed, al_press_pulse, al_release_pulse, al_long_pulse};
  assign exp_vec   = {m_lvl, m_pp, m_rp, m_lp};
  assign btn_raw_n = ~btn_raw;

  always #5 clk = ~clk;

  button_events #(.N_BUTTONS(3), .DEBOUNCE_CYCLES(DC), .LONG_CYCLES(LC), .ACTIVE_LOW(0)
`ifdef BUTTON_EVENTS_REPEAT_EN
    , .REPEAT_CYCLES(RC)
`endif
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .pressed(pressed),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .long_pulse(long_pulse)
  );

  button_events #(.N_BUTTONS(3), .DEBOUNCE_CYCLES(DC), .LONG_CYCLES(LC), .ACTIVE_LOW(1)
`ifdef BUTTON_EVENTS_REPEAT_EN
    , .REPEAT_CYCLES(RC)
`endif
  ) dut_al (
    .clk(clk), .reset(reset), .btn_raw(btn_raw_n), .pressed(al_pressed),
    .press_pulse(al_press_pulse), .release_pulse(al_release_pulse), .long_pulse(al_long_pulse)
  );

  // Level flips after DC consecutive synced samples disagreeing with it; hold age drives long/repeat.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_d1 <= '0; m_d2 <= '0; m_prev_s <= '0;
      m_lvl <= '0; m_pp <= '0; m_rp <= '0; m_lp <= '0;
      for (int i = 0; i < 3; i++) begin
        m_run[i] <= 0; m_age[i] <= 0; m_rep[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        automatic bit s   = m_d2[i];
        automatic bit lvl = m_lvl[i];
        automatic int run = m_run[i];
        automatic int age = m_age[i];
        automatic int rep = m_rep[i];
        automatic bit pp = 1'b0, rp = 1'b0, lp = 1'b0;
        if (lvl) begin
          if (age == LC - 1) begin
            lp  = 1'b1;
            rep = 0;
          end
`ifdef BUTTON_EVENTS_REPEAT_EN
          else if (m_prev_s[i] && age >= LC) begin
            rep = rep + 1;
            if (rep == RC) begin
              pp  = 1'b1;
              rep = 0;
            end
          end
`endif
          if (age < LC) age = age + 1;
        end
        run = (s != lvl) ? run + 1 : 0;
        if (run == DC) begin
          lvl = s;
          run = 0;
          if (s) begin
            pp  = 1'b1;
            age = 0;
          end else begin
            rp = 1'b1;
          end
        end
        m_lvl[i] <= lvl; m_pp[i] <= pp; m_rp[i] <= rp; m_lp[i] <= lp;
        m_run[i] <= run; m_age[i] <= age; m_rep[i] <= rep;
        m_prev_s[i] <= s; m_d2[i] <= m_d1[i]; m_d1[i] <= btn_raw[i];
      end
    end
  end

  task automatic settle(input int n);
    btn_raw = 3'b000;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if (dut_vec !== 12'h000 || al_vec !== 12'h000) begin
      errors++; $display("FAIL reset_state got=%h al=%h exp=000", dut_vec, al_vec);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (dut_vec !== 12'h000 || al_vec !== 12'h000) begin
      errors++; $display("FAIL idle_after_reset got=%h al=%h exp=000", dut_vec, al_vec);
    end
  endtask

  task automatic test_clean_press;
    btn_raw = 3'b001;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec || al_vec !== exp_vec) begin
        errors++; $display("FAIL clean_model k=%0d got=%h al=%h exp=%h", k, dut_vec, al_vec, exp_vec);
      end
      checks++;
      if (press_pulse !== ((k == 5) ? 3'b001 : 3'b000) || pressed !== ((k >= 5) ? 3'b001 : 3'b000)) begin
        errors++; $display("FAIL clean_press k=%0d pressed=%b press_pulse=%b", k, pressed, press_pulse);
      end
    end
    btn_raw = 3'b000;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if (release_pulse !== ((k == 5) ? 3'b001 : 3'b000) || pressed !== ((k < 5) ? 3'b001 : 3'b000)) begin
        errors++; $display("FAIL clean_release k=%0d pressed=%b release_pulse=%b", k, pressed, release_pulse);
      end
    end
  endtask

  task automatic test_bounce;
    logic [8:0] pat = 9'b111101101;
    int n_press = 0;
    int k_press = -1;
    for (int k = 0; k < 16; k++) begin
      btn_raw[1] = (k < 9) ? pat[k] : 1'b1;
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec || al_vec !== exp_vec) begin
        errors++; $display("FAIL bounce_model k=%0d got=%h al=%h exp=%h", k, dut_vec, al_vec, exp_vec);
      end
      if (press_pulse[1]) begin
        n_press++;
        if (k_press < 0) k_press = k;
      end
    end
    checks++;
    if (n_press !== 1 || k_press !== 10) begin
      errors++; $display("FAIL bounce_press count=%0d at=%0d exp count=1 at=10", n_press, k_press);
    end
    settle(12);
  endtask

  task automatic test_long;
    int k_press = -1, k_long = -1, k_rel = -1, n_long = 0;
    btn_raw = 3'b100;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec || al_vec !== exp_vec) begin
        errors++; $display("FAIL long_model k=%0d got=%h al=%h exp=%h", k, dut_vec, al_vec, exp_vec);
      end
      if (press_pulse[2] && k_press < 0) k_press = k;
      if (long_pulse[2]) begin
        n_long++;
        k_long = k;
      end
      if (release_pulse[2]) k_rel = k;
      if (k_press >= 0 && k == k_press + 30) btn_raw = 3'b000;
    end
    checks++;
    if (k_press !== 5 || k_long - k_press !== LC || n_long !== 1) begin
      errors++; $display("FAIL long_pulse press=%0d long=%0d count=%0d exp press=5 long=25 count=1",
                         k_press, k_long, n_long);
    end
    checks++;
    if (k_rel !== 41) begin
      errors++; $display("FAIL long_release at=%0d exp=41", k_rel);
    end
    settle(8);
  endtask

  task automatic test_release_glitch;
    int n_press = 0, n_rel = 0;
    for (int k = 0; k < 13; k++) begin
      btn_raw[0] = (k == 8 || k == 9) ? 1'b0 : 1'b1;
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec || al_vec !== exp_vec) begin
        errors++; $display("FAIL glitch_model k=%0d got=%h al=%h exp=%h", k, dut_vec, al_vec, exp_vec);
      end
      if (k >= 5) begin
        checks++;
        if (pressed[0] !== 1'b1) begin
          errors++; $display("FAIL glitch_level k=%0d pressed=%b exp=1", k, pressed[0]);
        end
      end
      n_press += int'(press_pulse[0]);
      n_rel   += int'(release_pulse[0]);
    end
    checks++;
    if (n_press !== 1 || n_rel !== 0) begin
      errors++; $display("FAIL glitch_pulses press=%0d release=%0d exp press=1 release=0", n_press, n_rel);
    end
    settle(12);
  endtask

  task automatic test_simultaneous;
    btn_raw = 3'b111;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (press_pulse !== ((k == 5) ? 3'b111 : 3'b000) || dut_vec !== exp_vec || al_vec !== exp_vec) begin
        errors++; $display("FAIL simultaneous k=%0d press_pulse=%b got=%h exp=%h", k, press_pulse, dut_vec, exp_vec);
      end
    end
    settle(12);
  endtask

  task automatic test_reset_mid_held;
    btn_raw = 3'b001;
    repeat (8) @(negedge clk);
    checks++;
    if (pressed !== 3'b001) begin
      errors++; $display("FAIL reset_mid_pre pressed=%b exp=001", pressed);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (dut_vec !== 12'h000 || al_vec !== 12'h000) begin
      errors++; $display("FAIL reset_async got=%h al=%h exp=000", dut_vec, al_vec);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (press_pulse !== ((k == 5) ? 3'b001 : 3'b000) || dut_vec !== exp_vec || al_vec !== exp_vec) begin
        errors++; $display("FAIL reset_repress k=%0d press_pulse=%b got=%h exp=%h", k, press_pulse, dut_vec, exp_vec);
      end
    end
    settle(12);
  endtask

  task automatic test_random;
    int seg[3] = '{0, 0, 0};
    for (int c = 0; c < 1200; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (seg[i] == 0) begin
          btn_raw[i] = ~btn_raw[i];
          seg[i] = int'($urandom_range(1, 32));
        end
        seg[i]--;
      end
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec || al_vec !== exp_vec) begin
        errors++; $display("FAIL random_model c=%0d got=%h al=%h exp=%h", c, dut_vec, al_vec, exp_vec);
      end
    end
    settle(12);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long();
    test_release_glitch();
    test_simultaneous();
    test_reset_mid_held();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
